// File: rtl/cv32e40p_apu_disp_mq.sv
// cv32e40p_apu_disp_mq -- multi-outstanding APU dispatcher.
// Sits between the ID stage and the APU interconnect. Accepted requests are
// tracked in an in-order FIFO of destination register addresses, so each
// in-order response can report its write address. It also produces RAW/WAW
// hazard flags and stall reasons for the decoder.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   enable_i, apu_lat_i, apu_waddr_i  issue request from the decoder
//   apu_req_o, apu_gnt_i, apu_rvalid_i  interconnect handshake
//   apu_waddr_o                       destination of the op returning this cycle
//   apu_multicycle_o                  last issued op was latency class 3
//   apu_singlecycle_o, active_o       FIFO empty / non-empty
//   count_o                           FIFO occupancy
//   stall_o                           full | type | nack stall
//   is_decoding_i, read_regs_*, write_regs_*  dependency query
//   read_dep_o, write_dep_o           RAW / WAW hazard
//   perf_type_o, perf_cont_o          stall_type / stall_nack this cycle
//   perf_type_cnt_o, perf_cont_cnt_o  saturating stall counters
//
// Build option: define CV32E40P_APU_DISP_PERF_EN to enable the stall counters;
// otherwise the counter ports are tied to zero.
module cv32e40p_apu_disp_mq #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned N_RD   = 3,
  parameter int unsigned N_WR   = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic [1:0]                 apu_lat_i,
  input  logic [ADDR_W-1:0]          apu_waddr_i,
  output logic [ADDR_W-1:0]          apu_waddr_o,
  output logic                       apu_multicycle_o,
  output logic                       apu_singlecycle_o,
  output logic                       active_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       stall_o,
  input  logic                       is_decoding_i,
  input  logic [N_RD*ADDR_W-1:0]     read_regs_i,
  input  logic [N_RD-1:0]            read_regs_valid_i,
  output logic                       read_dep_o,
  input  logic [N_WR*ADDR_W-1:0]     write_regs_i,
  input  logic [N_WR-1:0]            write_regs_valid_i,
  output logic                       write_dep_o,
  output logic                       perf_type_o,
  output logic                       perf_cont_o,
  output logic [15:0]                perf_type_cnt_o,
  output logic [15:0]                perf_cont_cnt_o,
  output logic                       apu_req_o,
  input  logic                       apu_gnt_i,
  input  logic                       apu_rvalid_i
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] fifo_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        lat_last_q, lat_last_d;

  logic active, stall_full, stall_type, stall_nack;
  logic valid_req, req_acc, returned_req, push, pop;
  logic read_match, write_match;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic port_hit_rd(input logic [ADDR_W-1:0] a,
                                       input logic [N_RD*ADDR_W-1:0] regs,
                                       input logic [N_RD-1:0] vld);
    logic hit;
    hit = 1'b0;
    for (int unsigned j = 0; j < N_RD; j++)
      if (vld[j] && regs[j*ADDR_W +: ADDR_W] == a) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic port_hit_wr(input logic [ADDR_W-1:0] a,
                                       input logic [N_WR*ADDR_W-1:0] regs,
                                       input logic [N_WR-1:0] vld);
    logic hit;
    hit = 1'b0;
    for (int unsigned j = 0; j < N_WR; j++)
      if (vld[j] && regs[j*ADDR_W +: ADDR_W] == a) hit = 1'b1;
    return hit;
  endfunction

  always_comb begin
    active     = (count_q != '0);
    stall_full = (count_q == CNT_W'(DEPTH));
    // A younger op must never be able to complete before an older one.
    stall_type = enable_i & active &
                 ((apu_lat_i == 2'd1) | (apu_lat_i == 2'd3) | (apu_lat_i < lat_last_q));
    valid_req    = enable_i & ~stall_full & ~stall_type;
    req_acc      = valid_req & apu_gnt_i;
    stall_nack   = valid_req & ~apu_gnt_i;
    pop          = apu_rvalid_i & active;
    // Pop wins the response; a zero-latency return is only possible when empty.
    returned_req = req_acc & apu_rvalid_i & ~active;
    push         = req_acc & ~returned_req;

    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    lat_last_d = req_acc ? apu_lat_i : lat_last_q;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    vld_d = vld_q;
    if (pop)  vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = 1'b1;

    if (pop)               apu_waddr_o = fifo_q[rd_ptr_q];
    else if (returned_req) apu_waddr_o = apu_waddr_i;
    else                   apu_waddr_o = '0;

    // The head retiring this cycle no longer blocks; the in-progress request does.
    read_match  = 1'b0;
    write_match = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !(pop && rd_ptr_q == PTR_W'(i))) begin
        if (port_hit_rd(fifo_q[i], read_regs_i, read_regs_valid_i))   read_match  = 1'b1;
        if (port_hit_wr(fifo_q[i], write_regs_i, write_regs_valid_i)) write_match = 1'b1;
      end
    end
    if (valid_req && !returned_req) begin
      if (port_hit_rd(apu_waddr_i, read_regs_i, read_regs_valid_i))   read_match  = 1'b1;
      if (port_hit_wr(apu_waddr_i, write_regs_i, write_regs_valid_i)) write_match = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      vld_q      <= '0;
      lat_last_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      vld_q      <= vld_d;
      lat_last_q <= lat_last_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= apu_waddr_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i)
      assert (!(apu_rvalid_i && !active && !req_acc))
        else $error("apu_rvalid_i without an outstanding APU op");
  end

  assign apu_multicycle_o  = (lat_last_q == 2'd3);
  assign apu_singlecycle_o = ~active;
  assign active_o          = active;
  assign count_o           = count_q;
  assign stall_o           = stall_full | stall_type | stall_nack;
  assign read_dep_o        = is_decoding_i & read_match;
  assign write_dep_o       = is_decoding_i & write_match;
  assign perf_type_o       = stall_type;
  assign perf_cont_o       = stall_nack;
  assign apu_req_o         = valid_req;

`ifdef CV32E40P_APU_DISP_PERF_EN
  logic [15:0] perf_type_cnt_q, perf_type_cnt_d, perf_cont_cnt_q, perf_cont_cnt_d;

  always_comb begin
    perf_type_cnt_d = perf_type_cnt_q;
    perf_cont_cnt_d = perf_cont_cnt_q;
    if (stall_type && perf_type_cnt_q != '1) perf_type_cnt_d = perf_type_cnt_q + 1'b1;
    if (stall_nack && perf_cont_cnt_q != '1) perf_cont_cnt_d = perf_cont_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_type_cnt_q <= '0;
      perf_cont_cnt_q <= '0;
    end else begin
      perf_type_cnt_q <= perf_type_cnt_d;
      perf_cont_cnt_q <= perf_cont_cnt_d;
    end
  end

  assign perf_type_cnt_o = perf_type_cnt_q;
  assign perf_cont_cnt_o = perf_cont_cnt_q;
`else
  assign perf_type_cnt_o = '0;
  assign perf_cont_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_apu_disp_mq.sv
// Testbench for cv32e40p_apu_disp_mq: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_cv32e40p_apu_disp_mq;

  localparam int DEPTH = 4;

`ifdef CV32E40P_APU_DISP_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [1:0]  apu_lat_i;
  logic [5:0]  apu_waddr_i;
  logic [5:0]  apu_waddr_o;
  logic        apu_multicycle_o, apu_singlecycle_o, active_o;
  logic [2:0]  count_o;
  logic        stall_o, is_decoding_i;
  logic [17:0] read_regs_i;
  logic [2:0]  read_regs_valid_i;
  logic        read_dep_o;
  logic [11:0] write_regs_i;
  logic [1:0]  write_regs_valid_i;
  logic        write_dep_o, perf_type_o, perf_cont_o;
  logic [15:0] perf_type_cnt_o, perf_cont_cnt_o;
  logic        apu_req_o, apu_gnt_i, apu_rvalid_i;

  cv32e40p_apu_disp_mq #(.DEPTH(4), .ADDR_W(6), .N_RD(3), .N_WR(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .apu_lat_i(apu_lat_i),
    .apu_waddr_i(apu_waddr_i), .apu_waddr_o(apu_waddr_o),
    .apu_multicycle_o(apu_multicycle_o), .apu_singlecycle_o(apu_singlecycle_o),
    .active_o(active_o), .count_o(count_o), .stall_o(stall_o),
    .is_decoding_i(is_decoding_i), .read_regs_i(read_regs_i),
    .read_regs_valid_i(read_regs_valid_i), .read_dep_o(read_dep_o),
    .write_regs_i(write_regs_i), .write_regs_valid_i(write_regs_valid_i),
    .write_dep_o(write_dep_o), .perf_type_o(perf_type_o), .perf_cont_o(perf_cont_o),
    .perf_type_cnt_o(perf_type_cnt_o), .perf_cont_cnt_o(perf_cont_cnt_o),
    .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i), .apu_rvalid_i(apu_rvalid_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: in-flight destinations in issue order.
  int q[$];
  int lat_last;
  int ptc, pcc;

  int checks = 0;
  int failures = 0;

  logic [31:0] obs_waddr, obs_req, obs_stall, obs_count, obs_rdep, obs_wdep;
  logic [31:0] obs_ptype, obs_single, obs_multi, obs_ptc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic bit model_acc(input bit en, input logic [1:0] lat, input bit gnt);
    bit act, st;
    act = (q.size() != 0);
    st  = en && act && (lat == 2'd1 || lat == 2'd3 || int'(lat) < lat_last);
    return en && (q.size() != DEPTH) && !st && gnt;
  endfunction

  task automatic cycle(input bit en, input logic [1:0] lat, input logic [5:0] wa,
                       input bit gnt, input bit rv, input bit dec,
                       input logic [17:0] rr, input logic [2:0] rrv,
                       input logic [11:0] wr, input logic [1:0] wrv);
    int n, ewa;
    bit act, full, st, vr, acc, nack, pop, ret, rdep, wdep;
    int chkq[$];
    enable_i = en; apu_lat_i = lat; apu_waddr_i = wa; apu_gnt_i = gnt;
    apu_rvalid_i = rv; is_decoding_i = dec; read_regs_i = rr;
    read_regs_valid_i = rrv; write_regs_i = wr; write_regs_valid_i = wrv;
    #1;
    n    = q.size();
    act  = (n != 0);
    full = (n == DEPTH);
    st   = en && act && (lat == 2'd1 || lat == 2'd3 || int'(lat) < lat_last);
    vr   = en && !full && !st;
    acc  = vr && gnt;
    nack = vr && !gnt;
    pop  = rv && act;
    ret  = acc && rv && !act;
    ewa  = pop ? q[0] : (ret ? int'(wa) : 0);
    chkq = q;
    if (pop) void'(chkq.pop_front());
    if (vr && !ret) chkq.push_back(int'(wa));
    rdep = 0; wdep = 0;
    foreach (chkq[k]) begin
      for (int j = 0; j < 3; j++) if (rrv[j] && int'(rr[j*6 +: 6]) == chkq[k]) rdep = 1;
      for (int j = 0; j < 2; j++) if (wrv[j] && int'(wr[j*6 +: 6]) == chkq[k]) wdep = 1;
    end
    rdep = rdep && dec;
    wdep = wdep && dec;

    obs_waddr = 32'(apu_waddr_o); obs_req = 32'(apu_req_o); obs_stall = 32'(stall_o);
    obs_count = 32'(count_o); obs_rdep = 32'(read_dep_o); obs_wdep = 32'(write_dep_o);
    obs_ptype = 32'(perf_type_o); obs_single = 32'(apu_singlecycle_o);
    obs_multi = 32'(apu_multicycle_o); obs_ptc = 32'(perf_type_cnt_o);

    chk("waddr",      32'(apu_waddr_o),       32'(ewa));
    chk("multicycle", 32'(apu_multicycle_o),  32'(lat_last == 3));
    chk("single",     32'(apu_singlecycle_o), 32'(!act));
    chk("active",     32'(active_o),          32'(act));
    chk("count",      32'(count_o),           32'(n));
    chk("stall",      32'(stall_o),           32'(full || st || nack));
    chk("req",        32'(apu_req_o),         32'(vr));
    chk("read_dep",   32'(read_dep_o),        32'(rdep));
    chk("write_dep",  32'(write_dep_o),       32'(wdep));
    chk("perf_type",  32'(perf_type_o),       32'(st));
    chk("perf_cont",  32'(perf_cont_o),       32'(nack));
    chk("type_cnt",   32'(perf_type_cnt_o),   PERF_EN ? 32'(ptc) : 32'd0);
    chk("cont_cnt",   32'(perf_cont_cnt_o),   PERF_EN ? 32'(pcc) : 32'd0);

    @(posedge clk_i); #1;
    if (acc) lat_last = int'(lat);
    if (pop) void'(q.pop_front());
    if (acc && !ret) q.push_back(int'(wa));
    if (st && ptc < 65535) ptc++;
    if (nack && pcc < 65535) pcc++;
  endtask

  task automatic idle();
    cycle(0, 2'd0, 6'd0, 0, 0, 0, '0, '0, '0, '0);
  endtask

  task automatic issue(input logic [1:0] lat, input logic [5:0] wa);
    cycle(1, lat, wa, 1, 0, 0, '0, '0, '0, '0);
  endtask

  task automatic resp();
    cycle(0, 2'd0, 6'd0, 0, 1, 0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    enable_i = 0; apu_lat_i = '0; apu_waddr_i = '0; apu_gnt_i = 0; apu_rvalid_i = 0;
    is_decoding_i = 0; read_regs_i = '0; read_regs_valid_i = '0;
    write_regs_i = '0; write_regs_valid_i = '0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    q.delete(); lat_last = 0; ptc = 0; pcc = 0;
  endtask

  initial begin
    bit en, gnt, rv, dec;
    logic [1:0]  lat;
    logic [5:0]  wa;
    logic [17:0] rr;
    logic [11:0] wr;

    do_reset();

    // Idle after reset
    idle();
    chk("rst_waddr", obs_waddr, 32'd0);
    chk("rst_single", obs_single, 32'd1);
    chk("rst_count", obs_count, 32'd0);
    chk("rst_stall", obs_stall, 32'd0);
    chk("rst_req", obs_req, 32'd0);

    // Fill to DEPTH, then full stall; pop at full; push+pop at DEPTH-1
    for (int i = 0; i < 4; i++) issue(2'd2, 6'(10 + i));
    cycle(1, 2'd2, 6'd20, 1, 0, 0, '0, '0, '0, '0);
    chk("full_count", obs_count, 32'd4);
    chk("full_stall", obs_stall, 32'd1);
    chk("full_req", obs_req, 32'd0);
    cycle(1, 2'd2, 6'd21, 1, 1, 0, '0, '0, '0, '0);
    chk("full_pop_waddr", obs_waddr, 32'd10);
    chk("full_pop_req", obs_req, 32'd0);
    cycle(1, 2'd2, 6'd22, 1, 1, 0, '0, '0, '0, '0);
    chk("pushpop_req", obs_req, 32'd1);
    chk("pushpop_waddr", obs_waddr, 32'd11);
    resp();
    chk("pushpop_count", obs_count, 32'd3);
    chk("drain_waddr0", obs_waddr, 32'd12);
    resp();
    chk("drain_waddr1", obs_waddr, 32'd13);
    resp();
    chk("drain_waddr2", obs_waddr, 32'd22);

    // In-order return of 5,6,7
    issue(2'd2, 6'd5); issue(2'd2, 6'd6); issue(2'd2, 6'd7);
    resp(); chk("order0", obs_waddr, 32'd5);
    resp(); chk("order1", obs_waddr, 32'd6);
    resp(); chk("order2", obs_waddr, 32'd7);
    idle();
    chk("order_count", obs_count, 32'd0);
    chk("order_single", obs_single, 32'd1);

    // Zero-latency return
    cycle(1, 2'd2, 6'd9, 1, 1, 0, '0, '0, '0, '0);
    chk("zlat_waddr", obs_waddr, 32'd9);
    idle();
    chk("zlat_count", obs_count, 32'd0);

    // RAW/WAW hazards and release on the popping cycle
    issue(2'd2, 6'd3);
    cycle(0, 2'd0, 6'd0, 0, 0, 1, {6'd0, 6'd3, 6'd0}, 3'b010, '0, '0);
    chk("raw_hit", obs_rdep, 32'd1);
    cycle(0, 2'd0, 6'd0, 0, 1, 1, {6'd0, 6'd3, 6'd0}, 3'b010, '0, '0);
    chk("raw_pop", obs_rdep, 32'd0);
    chk("raw_pop_waddr", obs_waddr, 32'd3);
    issue(2'd2, 6'd4);
    cycle(0, 2'd0, 6'd0, 0, 0, 1, '0, '0, {6'd0, 6'd4}, 2'b01);
    chk("waw_hit", obs_wdep, 32'd1);
    cycle(0, 2'd0, 6'd0, 0, 1, 1, '0, '0, {6'd0, 6'd4}, 2'b01);
    chk("waw_pop", obs_wdep, 32'd0);
    cycle(1, 2'd2, 6'd12, 0, 0, 1, {6'd12, 6'd0, 6'd0}, 3'b100, '0, '0);
    chk("raw_req_nack", obs_rdep, 32'd1);

    // Type stall behind a multicycle op
    do_reset();
    issue(2'd3, 6'd8);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 2'd2, 6'd15, 1, 0, 0, '0, '0, '0, '0);
      chk("type_stall", obs_stall, 32'd1);
      chk("type_perf", obs_ptype, 32'd1);
      chk("type_multi", obs_multi, 32'd1);
    end
    idle();
    chk("type_cnt3", obs_ptc, PERF_EN ? 32'd3 : 32'd0);
    resp();

    // Random traffic; responses only where one is legal
    for (int c = 0; c < 600; c++) begin
      en  = ($urandom_range(0, 9) < 7);
      lat = 2'($urandom_range(0, 3));
      wa  = 6'($urandom_range(0, 7));
      gnt = ($urandom_range(0, 3) != 0);
      rv  = (q.size() != 0 || model_acc(en, lat, gnt)) ? 1'($urandom_range(0, 1)) : 1'b0;
      dec = 1'($urandom_range(0, 1));
      rr  = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      wr  = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      if (c % 200 == 199) do_reset();
      else cycle(en, lat, wa, gnt, rv, dec, rr, 3'($urandom), wr, 2'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
